// File: rtl/b11_stim_driver_if.sv
// Signal bundle between the b11 stimulus driver and its environment:
// upstream character feed, the b11 input/strobe port and the result return.
interface b11_stim_driver_if;
    logic       in_valid;
    logic [5:0] in_data;
    logic       in_ready;
    logic [5:0] x_in;
    logic       stbi;
    logic [5:0] dut_x_out;
    logic       res_valid;
    logic [5:0] res_data;
    logic [5:0] res_char;
    logic       busy;

    // Environment side: supplies characters, hosts b11, consumes results.
    modport master (
        output in_valid, in_data, dut_x_out,
        input  in_ready, x_in, stbi, res_valid, res_data, res_char, busy
    );

    // Driver side.
    modport slave (
        input  in_valid, in_data, dut_x_out,
        output in_ready, x_in, stbi, res_valid, res_data, res_char, busy
    );
endinterface

// File: rtl/b11_stim_driver.sv
// Transmit-side partner for the b11 scrambler. Queues 6-bit characters,
// strobes each into b11 for one cycle, waits a fixed gap, then returns the
// b11 output tagged with the character that produced it.
module b11_stim_driver #(
    parameter int DEPTH   = 4,
    parameter int GAP     = 16,
    parameter int STARTUP = 2
) (
    input  logic             clock,
    input  logic             reset,
    b11_stim_driver_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARTUP + 1);

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [SW-1:0] INIT_LAST  = SW'(STARTUP - 1);
    localparam logic [4:0]    WAIT_LAST  = 5'(GAP - 2);

    localparam logic [2:0] S_INIT    = 3'd0;
    localparam logic [2:0] S_IDLE    = 3'd1;
    localparam logic [2:0] S_STROBE  = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_CAPTURE = 3'd4;

    logic [2:0]    state;
    logic [5:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] next_count;
    logic [SW-1:0] init_cnt;
    logic [4:0]    wait_cnt;

    logic          ready_reg;
    logic          stbi_reg;
    logic [5:0]    char_reg;
    logic          busy_reg;
    logic          res_valid_reg;
    logic [5:0]    res_data_reg;
    logic [5:0]    res_char_reg;

    logic          push;
    logic          pop;
    logic          may_strobe;
    logic [5:0]    head;

    assign bus.in_ready  = ready_reg;
    assign bus.stbi      = stbi_reg;
    assign bus.x_in      = char_reg;
    assign bus.busy      = busy_reg;
    assign bus.res_valid = res_valid_reg;
    assign bus.res_data  = res_data_reg;
    assign bus.res_char  = res_char_reg;

    // Decide push/pop for this cycle; an empty FIFO forwards the incoming word so it can strobe next cycle.
    always_comb begin
        push = bus.in_valid && ready_reg;
        head = (count != '0) ? mem[rd_ptr] : bus.in_data;
        case (state)
            S_INIT:             may_strobe = (init_cnt == INIT_LAST);
            S_IDLE, S_CAPTURE:  may_strobe = 1'b1;
            default:            may_strobe = 1'b0;
        endcase
        pop = may_strobe && ((count != '0) || push);
        next_count = count;
        if (push && !pop) begin
            next_count = count + 1'b1;
        end else if (pop && !push) begin
            next_count = count - 1'b1;
        end
    end

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    // FIFO pointers, occupancy and the registered ready flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ready_reg <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count     <= next_count;
            ready_reg <= (next_count != FULL_COUNT);
        end
    end

    // Strobe sequencer: outputs are loaded on the edge entering each state so they are all registered.
    // The result is sampled on the last WAIT cycle so res_valid and res_data appear together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= S_INIT;
            init_cnt      <= '0;
            wait_cnt      <= '0;
            stbi_reg      <= 1'b1;
            char_reg      <= '0;
            busy_reg      <= 1'b0;
            res_valid_reg <= 1'b0;
            res_data_reg  <= '0;
            res_char_reg  <= '0;
        end else begin
            res_valid_reg <= 1'b0;
            stbi_reg      <= 1'b1;
            if (pop) begin
                state    <= S_STROBE;
                stbi_reg <= 1'b0;
                char_reg <= head;
                busy_reg <= 1'b1;
            end else begin
                case (state)
                    S_INIT: begin
                        if (init_cnt == INIT_LAST) begin
                            state <= S_IDLE;
                        end else begin
                            init_cnt <= init_cnt + 1'b1;
                        end
                    end
                    S_IDLE: begin
                        busy_reg <= 1'b0;
                    end
                    S_STROBE: begin
                        state    <= S_WAIT;
                        wait_cnt <= '0;
                    end
                    S_WAIT: begin
                        if (wait_cnt == WAIT_LAST) begin
                            state         <= S_CAPTURE;
                            res_valid_reg <= 1'b1;
                            res_data_reg  <= bus.dut_x_out;
                            res_char_reg  <= char_reg;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    S_CAPTURE: begin
                        state    <= S_IDLE;
                        busy_reg <= 1'b0;
                    end
                    default: begin
                        state    <= S_IDLE;
                        busy_reg <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
